vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel counters plus registered de/hsync/vsync/frame_start decodes.
// Optional macro VGA_TIMING_SYNC_DLY_EN delays the decodes by SYNC_DLY enabled strobes.
module vga_timing_gen #(
   parameter int unsigned PIX_WIDTH = 12,
   parameter int unsigned H_ACTIVE  = 1280,
   parameter int unsigned H_FP      = 48,
   parameter int unsigned H_SYNC    = 112,
   parameter int unsigned H_BP      = 248,
   parameter int unsigned V_ACTIVE  = 1024,
   parameter int unsigned V_FP      = 1,
   parameter int unsigned V_SYNC    = 3,
   parameter int unsigned V_BP      = 38,
   parameter bit          HSYNC_POL = 1'b1,
   parameter bit          VSYNC_POL = 1'b1,
   parameter int unsigned SYNC_DLY  = 2
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic                 pix_en_i,
   output logic [PIX_WIDTH-1:0] pix_x_o,
   output logic [PIX_WIDTH-1:0] pix_y_o,
   output logic                 de_o,
   output logic                 hsync_o,
   output logic                 vsync_o,
   output logic                 frame_start_o
);

   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END    = H_ACTIVE + H_FP + H_SYNC;
   localparam int unsigned VS_START  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END    = V_ACTIVE + V_FP + V_SYNC;

   // Decode bundle layout: {frame_start, vsync, hsync, de}
   localparam logic [3:0] DEC_RST = {1'b0, ~VSYNC_POL, ~HSYNC_POL, 1'b0};

   if (H_TOTAL > 2**PIX_WIDTH) begin : g_h_total_chk
      $error("vga_timing_gen: H_TOTAL does not fit in PIX_WIDTH");
   end
   if (V_TOTAL > 2**PIX_WIDTH) begin : g_v_total_chk
      $error("vga_timing_gen: V_TOTAL does not fit in PIX_WIDTH");
   end

   logic [PIX_WIDTH-1:0] h_cnt;
   logic [PIX_WIDTH-1:0] v_cnt;
   logic [31:0]          h_ext;
   logic [31:0]          v_ext;
   logic                 h_last;
   logic                 v_last;
   logic [3:0]           dec_d;
   logic [3:0]           dec_r;
   logic [3:0]           dec_out;

   always_comb begin
      h_ext  = 32'(h_cnt);
      v_ext  = 32'(v_cnt);
      h_last = (h_ext == H_TOTAL - 1);
      v_last = (v_ext == V_TOTAL - 1);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en_i) begin
         if (h_last) begin
            h_cnt <= '0;
            if (v_last) v_cnt <= '0;
            else        v_cnt <= v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      dec_d    = DEC_RST;
      dec_d[0] = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
      dec_d[1] = ((h_ext >= HS_START) && (h_ext < HS_END)) ? HSYNC_POL : !HSYNC_POL;
      dec_d[2] = ((v_ext >= VS_START) && (v_ext < VS_END)) ? VSYNC_POL : !VSYNC_POL;
      dec_d[3] = (h_cnt == '0) && (v_cnt == '0);
   end

   // Coordinates and decodes share one register stage so they stay aligned.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         pix_x_o <= '0;
         pix_y_o <= '0;
         dec_r   <= DEC_RST;
      end else if (pix_en_i) begin
         pix_x_o <= h_cnt;
         pix_y_o <= v_cnt;
         dec_r   <= dec_d;
      end
   end

`ifdef VGA_TIMING_SYNC_DLY_EN
   if (SYNC_DLY < 1) begin : g_dly_chk
      $error("vga_timing_gen: SYNC_DLY must be at least 1");
   end

   logic [3:0] dly_q [SYNC_DLY];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int unsigned i = 0; i < SYNC_DLY; i++) dly_q[i] <= DEC_RST;
      end else if (pix_en_i) begin
         dly_q[0] <= dec_r;
         for (int unsigned i = 1; i < SYNC_DLY; i++) dly_q[i] <= dly_q[i-1];
      end
   end

   assign dec_out = dly_q[SYNC_DLY-1];
`else
   assign dec_out = dec_r;
`endif

   assign de_o          = dec_out[0];
   assign hsync_o       = dec_out[1];
   assign vsync_o       = dec_out[2];
   assign frame_start_o = dec_out[3];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster; the reference model maps the
// count of enabled strobes since reset straight to raster coordinates and decode levels.
module tb_vga_timing_gen;

   localparam int unsigned PW = 6;
   localparam int unsigned HA = 16, HF = 3, HS = 5, HB = 4;
   localparam int unsigned VA = 10, VF = 1, VS = 3, VB = 2;
   localparam int unsigned HT = HA + HF + HS + HB;
   localparam int unsigned VT = VA + VF + VS + VB;
   localparam int unsigned FRAME = HT * VT;
   localparam bit HP = 1'b1;
   localparam bit VP = 1'b0;
`ifdef VGA_TIMING_SYNC_DLY_EN
   localparam int unsigned DLY = 2;
`else
   localparam int unsigned DLY = 0;
`endif

   typedef struct packed {
      logic [PW-1:0] x;
      logic [PW-1:0] y;
      logic          de;
      logic          hs;
      logic          vs;
      logic          fs;
   } exp_t;

   logic          clk;
   logic          rstn;
   logic          pix_en;
   logic [PW-1:0] pix_x;
   logic [PW-1:0] pix_y;
   logic          de, hsync, vsync, frame_start;

   exp_t        sb[$];
   exp_t        cur;
   int unsigned n_en;
   int          checks = 0;
   int          passes = 0;

   vga_timing_gen #(
      .PIX_WIDTH(PW),
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .HSYNC_POL(HP), .VSYNC_POL(VP),
      .SYNC_DLY(2)
   ) dut (
      .clk_i(clk),
      .rstn_i(rstn),
      .pix_en_i(pix_en),
      .pix_x_o(pix_x),
      .pix_y_o(pix_y),
      .de_o(de),
      .hsync_o(hsync),
      .vsync_o(vsync),
      .frame_start_o(frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // n = enabled strobes since reset; strobe n shows raster pixel n-1, decodes lag by DLY.
   function automatic exp_t model(input int unsigned n);
      exp_t e;
      int unsigned k, xd, yd;
      e.x = '0; e.y = '0; e.de = 1'b0; e.hs = !HP; e.vs = !VP; e.fs = 1'b0;
      if (n == 0) return e;
      k = (n - 1) % FRAME;
      e.x = PW'(k % HT);
      e.y = PW'(k / HT);
      if (n > DLY) begin
         k  = (n - 1 - DLY) % FRAME;
         xd = k % HT;
         yd = k / HT;
         e.de = (xd < HA) && (yd < VA);
         e.hs = (xd >= HA + HF && xd < HA + HF + HS) ? HP : !HP;
         e.vs = (yd >= VA + VF && yd < VA + VF + VS) ? VP : !VP;
         e.fs = (k == 0);
      end
      return e;
   endfunction

   task automatic cycle(input logic en);
      pix_en = en;
      if (en) begin
         n_en++;
         cur = model(n_en);
      end
      sb.push_back(cur);
      @(negedge clk);
   endtask

   // Called at a falling edge; drops reset between clock edges, releases at the next falling edge.
   task automatic async_reset();
      #2;
      pix_en = 1'($urandom_range(0, 1));
      n_en = 0;
      cur = model(0);
      sb.push_back(cur);
      rstn = 1'b0;
      sb.push_back(cur);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin : monitor
      exp_t e, act;
      #1;
      forever begin
         @(posedge clk or negedge rstn);
         #1;
         act = {pix_x, pix_y, de, hsync, vsync, frame_start};
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_underflow t=%0t: output seen with no expectation queued", $time);
         end else begin
            e = sb.pop_front();
            if (act === e) passes++;
            else $display("FAIL outputs t=%0t got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b expected x=%0d y=%0d de=%b hs=%b vs=%b fs=%b",
                          $time, act.x, act.y, act.de, act.hs, act.vs, act.fs,
                          e.x, e.y, e.de, e.hs, e.vs, e.fs);
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "time limit");
   end

   initial begin : stimulus
      rstn   = 1'b0;
      pix_en = 1'b0;
      n_en   = 0;
      cur    = model(0);
      repeat (3) begin
         sb.push_back(cur);
         @(negedge clk);
      end
      rstn = 1'b1;

      repeat (2 * FRAME + 5) cycle(1'b1);

      async_reset();
      repeat (6 * HT + 9) cycle(1'b1);
      async_reset();
      repeat (HT + 3) cycle(1'b1);

      for (int i = 0; i < 2 * FRAME + 10; i++) cycle(i % 2 == 0);

      repeat (4000) begin
         if ($urandom_range(0, 599) == 0) async_reset();
         cycle($urandom_range(0, 3) != 0);
      end

      checks++;
      if (sb.size() == 0) passes++;
      else $display("FAIL sb_drain: got %0d pending expected 0", sb.size());

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
